// File: rtl/gate_pipe_unit.sv
// Two-stage pipelined bitwise gate unit: 3-to-8 opcode decode selects one of eight gates.
// Valid/ready on both sides sustains one op per clock; a saturating counter tallies output transfers.
module gate_pipe_unit #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] y,
    output logic [7:0]       y_sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] op_count,
    input  logic             clr_count
);

    typedef enum logic [2:0] {
        OP_AND  = 3'd0,
        OP_OR   = 3'd1,
        OP_NOT  = 3'd2,
        OP_XOR  = 3'd3,
        OP_NAND = 3'd4,
        OP_NOR  = 3'd5,
        OP_XNOR = 3'd6,
        OP_BUF  = 3'd7
    } op_e;

    logic             r_s1_valid;
    logic [WIDTH-1:0] r_s1_a;
    logic [WIDTH-1:0] r_s1_b;
    logic [7:0]       r_s1_sel;

    logic [WIDTH-1:0] r_y;
    logic [7:0]       r_y_sel;
    logic             r_out_valid;
    logic [CNT_W-1:0] r_op_count;

    logic             w_s2_free;
    logic             w_s1_adv;
    logic             w_in_ready;
    logic             w_in_xfer;
    logic             w_out_xfer;
    logic [7:0]       w_dec;
    logic [WIDTH-1:0] w_gate [8];
    logic [WIDTH-1:0] w_y;

    assign w_dec      = 8'b1 << op;
    assign w_s2_free  = !r_out_valid || out_ready;
    assign w_s1_adv   = r_s1_valid && w_s2_free;
    // in_ready is combinational from out_ready so a draining pipe can refill in the same cycle.
    assign w_in_ready = !r_s1_valid || w_s2_free;
    assign w_in_xfer  = in_valid && w_in_ready;
    assign w_out_xfer = r_out_valid && out_ready;

    assign w_gate[OP_AND]  = r_s1_a & r_s1_b;
    assign w_gate[OP_OR]   = r_s1_a | r_s1_b;
    assign w_gate[OP_NOT]  = ~r_s1_a;
    assign w_gate[OP_XOR]  = r_s1_a ^ r_s1_b;
    assign w_gate[OP_NAND] = ~(r_s1_a & r_s1_b);
    assign w_gate[OP_NOR]  = ~(r_s1_a | r_s1_b);
    assign w_gate[OP_XNOR] = ~(r_s1_a ^ r_s1_b);
    assign w_gate[OP_BUF]  = r_s1_a;

    always_comb begin
        // NOTE: assign a default before any conditional update so no path infers a latch.
        w_y = '0;
        for (int k = 0; k < 8; k++) begin
            if (r_s1_sel[k]) begin
                w_y = w_y | w_gate[k];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
            r_s1_valid <= 1'b0;
        end else if (w_in_xfer) begin
            r_s1_valid <= 1'b1;
        end else if (w_s1_adv) begin
            r_s1_valid <= 1'b0;
        end
    end

    // NOTE: stage-1 payload needs no reset; it is only consumed when r_s1_valid is set.
    always_ff @(posedge clk) begin
        if (w_in_xfer) begin
            r_s1_a   <= a;
            r_s1_b   <= b;
            r_s1_sel <= w_dec;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_y         <= '0;
            r_y_sel     <= '0;
            r_out_valid <= 1'b0;
        end else if (w_s1_adv) begin
            r_y         <= w_y;
            r_y_sel     <= r_s1_sel;
            r_out_valid <= 1'b1;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    // Clear wins over a same-cycle increment; the count sticks at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op_count <= '0;
        end else if (clr_count) begin
            r_op_count <= '0;
        end else if (w_out_xfer && (r_op_count != {CNT_W{1'b1}})) begin
            r_op_count <= r_op_count + 1'b1;
        end
    end

    assign in_ready  = w_in_ready;
    assign y         = r_y;
    assign y_sel     = r_y_sel;
    assign out_valid = r_out_valid;
    assign op_count  = r_op_count;

endmodule
